// File: rtl/serial_mantissa_subtractor.sv
// Digit-serial ready/valid mantissa subtractor: a - b, CHUNK bits per cycle, LSB first.
// Optional build macro SUB_ABS_EN: on a negative result, re-negate serially to return |a - b|.
module serial_mantissa_subtractor #(
  parameter int WIDTH = 24,
  parameter int CHUNK = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_in_a,
  input  logic [WIDTH-1:0] io_in_b,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_d,
  output logic             io_out_b
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("serial_mantissa_subtractor: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
`ifdef SUB_ABS_EN
    S_NEG  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t            state, state_next;
  logic [IDX_W-1:0]  idx;
  logic              borrow;
  logic [WIDTH-1:0]  a_reg, b_reg, res_reg;

  logic              accept, busy, last;
  logic [CHUNK-1:0]  min_chunk, sub_chunk, d_chunk;
  logic [CHUNK:0]    diff;
  logic              bo;
  logic [WIDTH+CHUNK-1:0] res_shift;
  logic [WIDTH-1:0]  res_next;

  assign accept = io_in_valid && io_in_ready;
  assign last   = (idx == LAST);
`ifdef SUB_ABS_EN
  assign busy   = (state == S_RUN) || (state == S_NEG);
`else
  assign busy   = (state == S_RUN);
`endif

  // One shared CHUNK-bit subtractor: a - b in RUN, 0 - r in NEG.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    min_chunk = a_reg[CHUNK-1:0];
    sub_chunk = b_reg[CHUNK-1:0];
`ifdef SUB_ABS_EN
    if (state == S_NEG) begin
      min_chunk = '0;
      sub_chunk = res_reg[CHUNK-1:0];
    end
`endif
    diff      = {1'b0, min_chunk} - {1'b0, sub_chunk} - {{CHUNK{1'b0}}, borrow};
    d_chunk   = diff[CHUNK-1:0];
    bo        = diff[CHUNK];
    // New chunk enters at the top; after N shifts the first chunk sits at bit 0.
    res_shift = {d_chunk, res_reg} >> CHUNK;
    res_next  = res_shift[WIDTH-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments only; reset here is synchronous.
  always_ff @(posedge clock) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept) state_next = S_RUN;
      S_RUN: begin
        if (last) begin
`ifdef SUB_ABS_EN
          state_next = bo ? S_NEG : S_DONE;
`else
          state_next = S_DONE;
`endif
        end
      end
`ifdef SUB_ABS_EN
      S_NEG:  if (last) state_next = S_DONE;
`endif
      S_DONE: if (io_out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    io_in_ready  = (state == S_IDLE);
    io_out_valid = (state == S_DONE);
  end

  // Chunk counter and borrow chain restart whenever a serial pass begins.
  always_ff @(posedge clock) begin
    if (reset) begin
      idx      <= '0;
      borrow   <= 1'b0;
      io_out_d <= '0;
      io_out_b <= 1'b0;
    end else begin
      if (busy && (state_next == state)) begin
        idx    <= idx + IDX_W'(1);
        borrow <= bo;
      end else begin
        idx    <= '0;
        borrow <= 1'b0;
      end
      if (busy && (state_next == S_DONE)) begin
        io_out_d <= res_next;
        io_out_b <= (state == S_RUN) ? bo : 1'b1;
      end
    end
  end

  // NOTE: operand/result shift registers carry no reset; they are always loaded before use.
  always_ff @(posedge clock) begin
    if (accept) begin
      a_reg <= io_in_a;
      b_reg <= io_in_b;
    end else if (state == S_RUN) begin
      a_reg <= a_reg >> CHUNK;
      b_reg <= b_reg >> CHUNK;
    end
    if (busy) res_reg <= res_next;
  end

endmodule

// File: tb/tb_serial_mantissa_subtractor.sv
// Directed self-checking bench for serial_mantissa_subtractor (WIDTH=24, CHUNK=8).
// Expectations follow SUB_ABS_EN when the bench is built with that macro.
module tb_serial_mantissa_subtractor;

  localparam int WIDTH = 24;
  localparam int CHUNK = 8;
  localparam int N     = WIDTH / CHUNK;
`ifdef SUB_ABS_EN
  localparam int LAT_NEG = 2 * N;
`else
  localparam int LAT_NEG = N;
`endif

  logic             clock = 1'b0;
  logic             reset;
  logic             io_in_valid;
  logic             io_in_ready;
  logic [WIDTH-1:0] io_in_a, io_in_b;
  logic             io_out_valid;
  logic             io_out_ready;
  logic [WIDTH-1:0] io_out_d;
  logic             io_out_b;

  int n_cmp = 0;
  int n_err = 0;

  serial_mantissa_subtractor #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_in_a      (io_in_a),
    .io_in_b      (io_in_b),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_out_d     (io_out_d),
    .io_out_b     (io_out_b)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for the result.
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] exp_d, input logic exp_b, input int exp_lat);
    int cyc;
    io_in_a     = a;
    io_in_b     = b;
    io_in_valid = 1'b1;
    check({tag, ".in_ready"}, 32'(io_in_ready), 32'd1);
    tick();
    io_in_valid = 1'b0;
    cyc = 0;
    while (!io_out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check({tag, ".latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, ".d"}, 32'(io_out_d), 32'(exp_d));
    check({tag, ".b"}, 32'(io_out_b), 32'(exp_b));
  endtask

  // Complete the output handshake; the result must stay visible afterwards.
  task automatic release_out(input string tag, input logic [WIDTH-1:0] exp_d);
    io_out_ready = 1'b1;
    tick();
    io_out_ready = 1'b0;
    check({tag, ".valid_low"}, 32'(io_out_valid), 32'd0);
    check({tag, ".ready_high"}, 32'(io_in_ready), 32'd1);
    check({tag, ".d_held"}, 32'(io_out_d), 32'(exp_d));
  endtask

  initial begin
    logic [WIDTH-1:0] neg_d;
    int cyc;

    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_in_a      = '0;
    io_in_b      = '0;
    io_out_ready = 1'b0;
    tick();
    tick();
    check("rst.in_ready", 32'(io_in_ready), 32'd1);
    check("rst.out_valid", 32'(io_out_valid), 32'd0);
    check("rst.d", 32'(io_out_d), 32'd0);
    check("rst.b", 32'(io_out_b), 32'd0);
    reset = 1'b0;
    tick();

    run_op("t1", 24'h000005, 24'h000003, 24'h000002, 1'b0, N);
    release_out("t1", 24'h000002);

`ifdef SUB_ABS_EN
    neg_d = 24'h000002;
`else
    neg_d = 24'hFFFFFE;
`endif
    run_op("t2", 24'h000003, 24'h000005, neg_d, 1'b1, LAT_NEG);
    release_out("t2", neg_d);

    run_op("t3a", 24'h010000, 24'h000001, 24'h00FFFF, 1'b0, N);
    release_out("t3a", 24'h00FFFF);

`ifdef SUB_ABS_EN
    neg_d = 24'hFFFFFF;
`else
    neg_d = 24'h000001;
`endif
    run_op("t3b", 24'h000000, 24'hFFFFFF, neg_d, 1'b1, LAT_NEG);
    release_out("t3b", neg_d);

    run_op("t3c", 24'h800000, 24'h7FFFFF, 24'h000001, 1'b0, N);
    release_out("t3c", 24'h000001);

    run_op("t3d", 24'hFFFFFF, 24'h000000, 24'hFFFFFF, 1'b0, N);
    release_out("t3d", 24'hFFFFFF);

    // Backpressure: result frozen and input blocked while consumer stalls.
    run_op("t4", 24'h000800, 24'h000001, 24'h0007FF, 1'b0, N);
    io_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t4.stall_valid", 32'(io_out_valid), 32'd1);
      check("t4.stall_d", 32'(io_out_d), 32'h0007FF);
      check("t4.stall_b", 32'(io_out_b), 32'd0);
      check("t4.stall_in_ready", 32'(io_in_ready), 32'd0);
    end
    io_in_valid = 1'b0;
    release_out("t4", 24'h0007FF);

    // Reset mid-RUN after two chunks have been processed.
    io_in_a     = 24'h000100;
    io_in_b     = 24'h000001;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    tick();
    tick();
    check("t5.in_run", 32'(io_in_ready), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5.in_ready", 32'(io_in_ready), 32'd1);
    check("t5.out_valid", 32'(io_out_valid), 32'd0);
    check("t5.d", 32'(io_out_d), 32'd0);
    check("t5.b", 32'(io_out_b), 32'd0);
    run_op("t5.new", 24'h123456, 24'h123456, 24'h000000, 1'b0, N);
    release_out("t5.new", 24'h000000);

    // Operands must be captured at accept.
    io_in_a     = 24'h000010;
    io_in_b     = 24'h000001;
    io_in_valid = 1'b1;
    tick();
    io_in_valid = 1'b0;
    io_in_a     = 24'hFFFFFF;
    cyc = 0;
    while (!io_out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("t6.latency", 32'(cyc), 32'(N));
    check("t6.d", 32'(io_out_d), 32'h00000F);
    check("t6.b", 32'(io_out_b), 32'd0);
    release_out("t6", 24'h00000F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
